// File: rtl/ttt_board_ctrl_if.sv
// Move handshake between the move source and the tic-tac-toe board controller.
interface ttt_board_ctrl_if;
  logic       move_valid;
  logic [3:0] move_pos;
  logic       move_ready;

  // Move source: offers a cell index, watches for the controller being ready.
  modport master (
    output move_valid,
    output move_pos,
    input  move_ready
  );

  // Board controller: takes moves, advertises when it can accept one.
  modport slave (
    input  move_valid,
    input  move_pos,
    output move_ready
  );
endinterface

// File: rtl/ttt_board_ctrl.sv
// Tic-tac-toe game controller: holds the board, validates moves, tracks
// turns, per-turn timeout and game end, and drives the board plus the
// side-to-move to the downstream win-threat checker.
module ttt_board_ctrl #(
  parameter logic [2:0]  P1_CODE     = 3'd3,
  parameter logic [2:0]  P2_CODE     = 3'd0,
  parameter logic [2:0]  EMPTY_CODE  = 3'd4,
  parameter int unsigned TIMEOUT_CYC = 1000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            new_game,
  ttt_board_ctrl_if.slave mv,
  output logic            move_err,
  output logic            timeout,
  output logic [2:0]      v11,
  output logic [2:0]      v12,
  output logic [2:0]      v13,
  output logic [2:0]      v21,
  output logic [2:0]      v22,
  output logic [2:0]      v23,
  output logic [2:0]      v31,
  output logic [2:0]      v32,
  output logic [2:0]      v33,
  output logic            p,
  output logic [3:0]      move_cnt,
  output logic            game_over,
  output logic [1:0]      winner
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] TCNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    S_PLAY,
    S_EVAL,
    S_OVER
  } state_t;

  state_t           state;
  logic [8:0][2:0]  board;
  logic [CNT_W-1:0] tcnt;
  logic             last_mover;
  logic             accept_p0;
  logic [2:0]       mark_p0;

  // True when pos addresses a real cell that is still empty; indices 9..15
  // never match a loop value and so read as occupied.
  function automatic logic cell_empty(input logic [8:0][2:0] b,
                                      input logic [3:0]      pos);
    logic e;
    e = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (pos == 4'(i)) e = (b[i] == EMPTY_CODE);
    end
    return e;
  endfunction

  function automatic logic three(input logic [2:0] a,
                                 input logic [2:0] c,
                                 input logic [2:0] d,
                                 input logic [2:0] code);
    return (a == code) && (c == code) && (d == code);
  endfunction

  // Any of the 8 lines (rows, columns, diagonals) fully owned by code.
  function automatic logic line_found(input logic [8:0][2:0] b,
                                      input logic [2:0]      code);
    return three(b[0], b[1], b[2], code) ||
           three(b[3], b[4], b[5], code) ||
           three(b[6], b[7], b[8], code) ||
           three(b[0], b[3], b[6], code) ||
           three(b[1], b[4], b[7], code) ||
           three(b[2], b[5], b[8], code) ||
           three(b[0], b[4], b[8], code) ||
           three(b[2], b[4], b[6], code);
  endfunction

  assign mv.move_ready = (state == S_PLAY);
  assign game_over     = (state == S_OVER);

  assign accept_p0 = mv.move_valid && cell_empty(board, mv.move_pos);
  assign mark_p0   = p ? P1_CODE : P2_CODE;

  assign v11 = board[0];
  assign v12 = board[1];
  assign v13 = board[2];
  assign v21 = board[3];
  assign v22 = board[4];
  assign v23 = board[5];
  assign v31 = board[6];
  assign v32 = board[7];
  assign v33 = board[8];

  // Game FSM: move acceptance, one-cycle line evaluation, turn timeout, restart.
  always_ff @(posedge clk) begin
    if (!rst_n || new_game) begin
      for (int i = 0; i < 9; i++) board[i] <= EMPTY_CODE;
      p          <= 1'b1;
      move_cnt   <= 4'd0;
      tcnt       <= '0;
      move_err   <= 1'b0;
      timeout    <= 1'b0;
      winner     <= 2'b00;
      last_mover <= 1'b1;
      state      <= S_PLAY;
    end else begin
      move_err <= 1'b0;
      timeout  <= 1'b0;
      case (state)
        S_PLAY: begin
          if (accept_p0) begin
            for (int i = 0; i < 9; i++) begin
              if (mv.move_pos == 4'(i)) board[i] <= mark_p0;
            end
            last_mover <= p;
            p          <= ~p;
            move_cnt   <= move_cnt + 4'd1;
            tcnt       <= '0;
            state      <= S_EVAL;
          end else begin
            // A rejected move does not restart the turn clock.
            if (mv.move_valid) move_err <= 1'b1;
            if (tcnt == TCNT_LAST) begin
              p       <= ~p;
              tcnt    <= '0;
              timeout <= 1'b1;
            end else begin
              tcnt <= tcnt + 1'b1;
            end
          end
        end
        S_EVAL: begin
          tcnt <= '0;
          if (line_found(board, last_mover ? P1_CODE : P2_CODE)) begin
            winner <= last_mover ? 2'b01 : 2'b10;
            state  <= S_OVER;
          end else if (move_cnt == 4'd9) begin
            winner <= 2'b11;
            state  <= S_OVER;
          end else begin
            state <= S_PLAY;
          end
        end
        S_OVER: begin
          tcnt <= '0;
        end
        default: begin
          state <= S_PLAY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ttt_board_ctrl.sv
// Testbench for ttt_board_ctrl: directed game scenarios with literal
// expectations, then randomized play checked every cycle against a
// board-level game model.
module tb_ttt_board_ctrl;

  localparam int P1 = 3;
  localparam int P2 = 0;
  localparam int E  = 4;
  localparam int TO = 8;

  logic       clk;
  logic       rst_n;
  logic       new_game;
  logic       move_err;
  logic       timeout;
  logic [2:0] v11, v12, v13, v21, v22, v23, v31, v32, v33;
  logic       p;
  logic [3:0] move_cnt;
  logic       game_over;
  logic [1:0] winner;
  logic [2:0] dv [9];

  int n_cmp;
  int n_bad;
  bit chk_en;

  // Game model state
  int m_board [9];
  int m_p, m_cnt, m_tcnt, m_win, m_mover;
  bit m_eval, m_over, m_err, m_to;

  ttt_board_ctrl_if bus ();

  ttt_board_ctrl #(
    .P1_CODE    (3'd3),
    .P2_CODE    (3'd0),
    .EMPTY_CODE (3'd4),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .new_game (new_game),
    .mv       (bus),
    .move_err (move_err),
    .timeout  (timeout),
    .v11      (v11),
    .v12      (v12),
    .v13      (v13),
    .v21      (v21),
    .v22      (v22),
    .v23      (v23),
    .v31      (v31),
    .v32      (v32),
    .v33      (v33),
    .p        (p),
    .move_cnt (move_cnt),
    .game_over(game_over),
    .winner   (winner)
  );

  assign dv[0] = v11;
  assign dv[1] = v12;
  assign dv[2] = v13;
  assign dv[3] = v21;
  assign dv[4] = v22;
  assign dv[5] = v23;
  assign dv[6] = v31;
  assign dv[7] = v32;
  assign dv[8] = v33;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic bit owns(int code, int a, int b, int c);
    return m_board[a] == code && m_board[b] == code && m_board[c] == code;
  endfunction

  function automatic bit m_won(int code);
    bit w;
    w = 0;
    for (int r = 0; r < 3; r++) begin
      if (owns(code, 3 * r, 3 * r + 1, 3 * r + 2)) w = 1;
      if (owns(code, r, r + 3, r + 6)) w = 1;
    end
    if (owns(code, 0, 4, 8) || owns(code, 2, 4, 6)) w = 1;
    return w;
  endfunction

  task automatic model_step(input bit rn, input bit ng, input bit v, input int pos);
    if (!rn || ng) begin
      for (int k = 0; k < 9; k++) m_board[k] = E;
      m_p = 1; m_cnt = 0; m_tcnt = 0; m_win = 0; m_mover = 1;
      m_eval = 0; m_over = 0; m_err = 0; m_to = 0;
    end else begin
      m_err = 0;
      m_to  = 0;
      if (m_eval) begin
        m_eval = 0;
        if (m_won(m_mover ? P1 : P2)) begin
          m_over = 1;
          m_win  = m_mover ? 1 : 2;
        end else if (m_cnt == 9) begin
          m_over = 1;
          m_win  = 3;
        end
      end else if (!m_over) begin
        if (v && pos <= 8 && m_board[pos] == E) begin
          m_board[pos] = m_p ? P1 : P2;
          m_mover = m_p;
          m_p     = 1 - m_p;
          m_cnt++;
          m_tcnt  = 0;
          m_eval  = 1;
        end else begin
          if (v) m_err = 1;
          m_tcnt++;
          if (m_tcnt == TO) begin
            m_p    = 1 - m_p;
            m_tcnt = 0;
            m_to   = 1;
          end
        end
      end
    end
  endtask

  // Drive one cycle of inputs, advance the model at the edge, settle.
  task automatic step(input bit rn, input bit ng, input bit v, input logic [3:0] pos);
    rst_n          = rn;
    new_game       = ng;
    bus.move_valid = v;
    bus.move_pos   = pos;
    @(posedge clk);
    model_step(rn, ng, v, int'(pos));
    #1;
  endtask

  task automatic play_move(input logic [3:0] pos);
    step(1'b1, 1'b0, 1'b1, pos);
    step(1'b1, 1'b0, 1'b0, 4'd0);
  endtask

  // Compare every output against the model on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("move_ready", int'(bus.move_ready), int'(!m_eval && !m_over));
      chk("move_err", int'(move_err), int'(m_err));
      chk("timeout", int'(timeout), int'(m_to));
      for (int k = 0; k < 9; k++) chk("cell", int'(dv[k]), m_board[k]);
      chk("p", int'(p), m_p);
      chk("move_cnt", int'(move_cnt), m_cnt);
      chk("game_over", int'(game_over), int'(m_over));
      if (m_over) chk("winner", int'(winner), m_win);
      else        chk("winner_idle", int'(winner), 0);
    end
  end

  initial begin
    bit rn, ng, v;
    logic [3:0] pos;
    n_cmp = 0;
    n_bad = 0;
    chk_en = 0;
    rst_n = 1'b0;
    new_game = 1'b0;
    bus.move_valid = 1'b0;
    bus.move_pos = 4'd0;

    // Reset values
    step(1'b0, 1'b0, 1'b0, 4'd0);
    chk_en = 1;
    chk("rst_ready", int'(bus.move_ready), 1);
    chk("rst_p", int'(p), 1);
    chk("rst_v22", int'(v22), 4);

    // Row win for player 1, with accept-to-ready latency
    step(1'b1, 1'b0, 1'b1, 4'd0);
    chk("t1_ready_eval", int'(bus.move_ready), 0);
    step(1'b1, 1'b0, 1'b0, 4'd0);
    chk("t1_ready_back", int'(bus.move_ready), 1);
    play_move(4'd3);
    play_move(4'd1);
    play_move(4'd4);
    play_move(4'd2);
    chk("t1_over", int'(game_over), 1);
    chk("t1_winner", int'(winner), 1);
    chk("t1_v11", int'(v11), 3);
    chk("t1_v12", int'(v12), 3);
    chk("t1_v13", int'(v13), 3);
    chk("t1_cnt", int'(move_cnt), 5);

    // Occupied cell
    step(1'b0, 1'b0, 1'b0, 4'd0);
    play_move(4'd4);
    step(1'b1, 1'b0, 1'b1, 4'd4);
    chk("t2_err", int'(move_err), 1);
    chk("t2_v22", int'(v22), 3);
    chk("t2_p", int'(p), 0);
    chk("t2_cnt", int'(move_cnt), 1);
    step(1'b1, 1'b0, 1'b0, 4'd0);
    chk("t2_err_drop", int'(move_err), 0);

    // Out-of-range positions
    step(1'b0, 1'b0, 1'b0, 4'd0);
    step(1'b1, 1'b0, 1'b1, 4'd9);
    chk("t3_err9", int'(move_err), 1);
    step(1'b1, 1'b0, 1'b1, 4'd15);
    chk("t3_err15", int'(move_err), 1);
    chk("t3_p", int'(p), 1);
    for (int k = 0; k < 9; k++) chk("t3_cell", int'(dv[k]), 4);

    // Draw
    step(1'b0, 1'b0, 1'b0, 4'd0);
    play_move(4'd0); play_move(4'd1); play_move(4'd2);
    play_move(4'd4); play_move(4'd3); play_move(4'd5);
    play_move(4'd7); play_move(4'd6); play_move(4'd8);
    chk("t4_winner", int'(winner), 3);
    chk("t4_cnt", int'(move_cnt), 9);
    chk("t4_ready", int'(bus.move_ready), 0);
    step(1'b1, 1'b0, 1'b1, 4'd0);
    chk("t4_no_err", int'(move_err), 0);

    // Timeout after TO idle cycles
    step(1'b0, 1'b0, 1'b0, 4'd0);
    for (int c = 1; c < TO; c++) begin
      step(1'b1, 1'b0, 1'b0, 4'd0);
      chk("t5_no_to_yet", int'(timeout), 0);
    end
    step(1'b1, 1'b0, 1'b0, 4'd0);
    chk("t5_to", int'(timeout), 1);
    chk("t5_p", int'(p), 0);
    step(1'b1, 1'b0, 1'b0, 4'd0);
    chk("t5_to_drop", int'(timeout), 0);
    // Legal move on the forfeit edge wins
    step(1'b0, 1'b0, 1'b0, 4'd0);
    for (int c = 1; c < TO; c++) step(1'b1, 1'b0, 1'b0, 4'd0);
    step(1'b1, 1'b0, 1'b1, 4'd4);
    chk("t5_move_wins", int'(timeout), 0);
    chk("t5_move_p", int'(p), 0);
    chk("t5_move_cnt", int'(move_cnt), 1);

    // new_game with a simultaneous move, then reset during EVAL
    step(1'b0, 1'b0, 1'b0, 4'd0);
    play_move(4'd0);
    play_move(4'd4);
    step(1'b1, 1'b1, 1'b1, 4'd8);
    chk("t6_v33", int'(v33), 4);
    chk("t6_p", int'(p), 1);
    chk("t6_cnt", int'(move_cnt), 0);
    chk("t6_err", int'(move_err), 0);
    step(1'b1, 1'b0, 1'b1, 4'd2);
    chk("t6_eval", int'(bus.move_ready), 0);
    step(1'b0, 1'b0, 1'b0, 4'd0);
    chk("t6_rst_ready", int'(bus.move_ready), 1);
    chk("t6_rst_v13", int'(v13), 4);
    chk("t6_rst_cnt", int'(move_cnt), 0);

    // Randomized play
    for (int i = 0; i < 4000; i++) begin
      rn  = ($urandom_range(0, 299) != 0);
      ng  = ($urandom_range(0, 149) == 0);
      v   = ($urandom_range(0, 9) < ((((i / 250) % 2) == 1) ? 7 : 2));
      pos = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(9, 15))
                                        : 4'($urandom_range(0, 8));
      step(rn, ng, v, pos);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
